// File: rtl/palin_pkg.sv
// Shared types and constants for the palindrome stream detector.
package palin_pkg;

    // Frame life-cycle: collect symbols, compare mirrored pairs, present verdict.
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CHECK  = 2'd1,
        RESULT = 2'd2
    } state_e;

    // Compare flavours selected by the mode input.
    localparam logic MODE_SYM = 1'b0;  // symbol-order palindrome
    localparam logic MODE_BIT = 1'b1;  // whole bit-string palindrome

endpackage : palin_pkg

// File: rtl/palin_sym_cmp.sv
// Combinational pair comparator: a == b (symbol mode) or a == bitrev(b)
// (bit mode). A middle symbol is compared against itself, which gives the
// required behaviour in both modes without special casing.
module palin_sym_cmp
    import palin_pkg::*;
#(
    parameter int SYM_W = 8
) (
    input  logic             mode,
    input  logic [SYM_W-1:0] sym_a,
    input  logic [SYM_W-1:0] sym_b,
    output logic             match
);

    logic [SYM_W-1:0] rev_b_s;

    // Bit-reverse the mirrored symbol and select the compare for the mode.
    always_comb begin
        rev_b_s = {SYM_W{1'b0}};
        for (int i = 0; i < SYM_W; i++) begin
            rev_b_s[i] = sym_b[SYM_W-1-i];
        end
        if (mode == MODE_BIT) begin
            match = (sym_a == rev_b_s);
        end else begin
            match = (sym_a == sym_b);
        end
    end

endmodule : palin_sym_cmp

// File: rtl/palin_stream_detector.sv
// Palindrome stream detector: buffers a frame of up to MAX_LEN symbols, then
// compares mirrored pairs one per cycle and presents a verdict.
// Optional macro PALIN_EARLY_EXIT_EN: leave CHECK on the first mismatch.
// Without it CHECK always lasts ceil(len/2) cycles (data-independent latency).
module palin_stream_detector
    import palin_pkg::*;
#(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SYM_W-1:0]             in_data,
    input  logic                         in_last,
    input  logic                         mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         is_palindrome,
    output logic                         overflow,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   k_q, k_d;          // low index of current pair
    logic [IDX_W-1:0]   hi_q, hi_d;        // mirrored index of current pair
    logic               match_q, match_d;  // all pairs so far matched
    logic               is_pal_q, is_pal_d;
    logic               ovf_out_q, ovf_out_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;

    logic [SYM_W-1:0]   buf_q [MAX_LEN];
    logic               wr_en_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               pair_eq_s;
    logic [IDX_W:0]     k_inc_s;
    logic               last_iter_s;

    assign wr_idx_s    = len_q[IDX_W-1:0];
    assign k_inc_s     = {1'b0, k_q} + {{IDX_W{1'b0}}, 1'b1};
    // Final pair reached once the two indices meet or become adjacent.
    assign last_iter_s = (k_inc_s >= {1'b0, hi_q});

    palin_sym_cmp #(
        .SYM_W (SYM_W)
    ) u_cmp (
        .mode  (mode_q),
        .sym_a (buf_q[k_q]),
        .sym_b (buf_q[hi_q]),
        .match (pair_eq_s)
    );

    // Frame buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[wr_idx_s] <= in_data;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            len_q       <= {LEN_W{1'b0}};
            ovf_q       <= 1'b0;
            mode_q      <= MODE_SYM;
            k_q         <= {IDX_W{1'b0}};
            hi_q        <= {IDX_W{1'b0}};
            match_q     <= 1'b0;
            is_pal_q    <= 1'b0;
            ovf_out_q   <= 1'b0;
            frame_len_q <= {LEN_W{1'b0}};
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            hi_q        <= hi_d;
            match_q     <= match_d;
            is_pal_q    <= is_pal_d;
            ovf_out_q   <= ovf_out_d;
            frame_len_q <= frame_len_d;
        end
    end

    // Next-state logic: accept symbols, walk mirrored pairs, hand off verdict.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        mode_d      = mode_q;
        k_d         = k_q;
        hi_d        = hi_q;
        match_d     = match_q;
        is_pal_d    = is_pal_q;
        ovf_out_d   = ovf_out_q;
        frame_len_d = frame_len_q;
        wr_en_s     = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    // Mode is latched with the first symbol of the frame.
                    if (len_q == {LEN_W{1'b0}}) begin
                        mode_d = mode;
                    end else begin
                        mode_d = mode_q;
                    end
                    if (len_q < LEN_MAX) begin
                        wr_en_s = 1'b1;
                        len_d   = len_q + LEN_W'(1);
                    end else if (!in_last) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (in_last) begin
                        if (ovf_q || (len_q == LEN_MAX)) begin
                            state_d     = RESULT;
                            is_pal_d    = 1'b0;
                            ovf_out_d   = 1'b1;
                            frame_len_d = LEN_MAX;
                        end else begin
                            state_d = CHECK;
                            k_d     = {IDX_W{1'b0}};
                            hi_d    = wr_idx_s;
                            match_d = 1'b1;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end

            CHECK: begin
                match_d = match_q & pair_eq_s;
                k_d     = k_q + IDX_W'(1);
                hi_d    = hi_q - IDX_W'(1);
                if (last_iter_s) begin
                    state_d     = RESULT;
                    is_pal_d    = match_q & pair_eq_s;
                    ovf_out_d   = 1'b0;
                    frame_len_d = len_q;
`ifdef PALIN_EARLY_EXIT_EN
                end else if (!pair_eq_s) begin
                    state_d     = RESULT;
                    is_pal_d    = 1'b0;
                    ovf_out_d   = 1'b0;
                    frame_len_d = len_q;
`endif
                end else begin
                    state_d = CHECK;
                end
            end

            RESULT: begin
                if (out_ready) begin
                    state_d = LOAD;
                    len_d   = {LEN_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = RESULT;
                end
            end

            default: begin
                state_d = LOAD;
                len_d   = {LEN_W{1'b0}};
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Handshake flags decode straight from the state register, so they are
    // glitch-free and mutually exclusive by construction.
    assign in_ready      = (state_q == LOAD);
    assign out_valid     = (state_q == RESULT);
    assign is_palindrome = is_pal_q;
    assign overflow      = ovf_out_q;
    assign frame_len     = frame_len_q;

endmodule : palin_stream_detector

// File: tb/tb_palin_stream_detector.sv
// Directed self-checking bench for palin_stream_detector (SYM_W=8, MAX_LEN=16).
`timescale 1ns/1ps
module tb_palin_stream_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic       is_palindrome;
    logic       overflow;
    logic [4:0] frame_len;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] frame_q [$];

    always #5 clk = ~clk;

    palin_stream_detector #(.SYM_W(8), .MAX_LEN(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .mode          (mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .is_palindrome (is_palindrome),
        .overflow      (overflow),
        .frame_len     (frame_len)
    );

    // Drive frame_q as one frame; returns with inputs idle, at a negedge.
    task automatic send_frame(input logic m, output bit ready_ok);
        ready_ok = 1'b1;
        for (int i = 0; i < frame_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            mode     = m;
            #1;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) ready_ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count cycles spent before out_valid rises (bounded).
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, is_palindrome, overflow, frame_len} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0})
            $display("FAIL reset: rdy/ov/pal/ovf/len got %b %b %b %b %0d want 1 0 0 0 0",
                     in_ready, out_valid, is_palindrome, overflow, frame_len);
        else pass_cnt++;
    endtask

    // Generic frame check: latency, verdict, overflow, length.
    task automatic run_frame(input string name, input logic m, input int exp_cyc,
                             input logic exp_pal, input logic exp_ovf, input logic [4:0] exp_len);
        bit ok;
        int cyc;
        send_frame(m, ok);
        wait_result(cyc);
        total_cnt++;
        if (!ok || cyc != exp_cyc || out_valid !== 1'b1 || in_ready !== 1'b0 ||
            is_palindrome !== exp_pal || overflow !== exp_ovf || frame_len !== exp_len)
            $display("FAIL %s: rdyok=%0d cyc=%0d ov=%b rdy=%b pal=%b ovf=%b len=%0d want rdyok=1 cyc=%0d ov=1 rdy=0 pal=%b ovf=%b len=%0d",
                     name, ok, cyc, out_valid, in_ready, is_palindrome, overflow, frame_len,
                     exp_cyc, exp_pal, exp_ovf, exp_len);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_sym_mode();
        frame_q = '{8'h12, 8'h34, 8'h12};
        run_frame("sym_123", 1'b0, 2, 1'b1, 1'b0, 5'd3);
        frame_q = '{8'h12, 8'h34, 8'h13};
        run_frame("sym_odd_neq", 1'b0, 2, 1'b0, 1'b0, 5'd3);
        frame_q = '{8'h37};
        run_frame("sym_single", 1'b0, 1, 1'b1, 1'b0, 5'd1);
    endtask

    task automatic test_bit_mode();
        frame_q = '{8'h01, 8'h80};
        run_frame("bit_0180", 1'b1, 1, 1'b1, 1'b0, 5'd2);
        frame_q = '{8'h01, 8'h80};
        run_frame("sym_0180", 1'b0, 1, 1'b0, 1'b0, 5'd2);
        frame_q = '{8'h37};
        run_frame("bit_single_no", 1'b1, 1, 1'b0, 1'b0, 5'd1);
        frame_q = '{8'h01, 8'h3C, 8'h80};
        run_frame("bit_mid_yes", 1'b1, 2, 1'b1, 1'b0, 5'd3);
        frame_q = '{8'h01, 8'h12, 8'h80};
        run_frame("bit_mid_no", 1'b1, 2, 1'b0, 1'b0, 5'd3);
    endtask

    task automatic test_overflow();
        frame_q = '{};
        for (int i = 0; i < 8; i++) frame_q.push_back(8'(i + 1));
        for (int i = 7; i >= 0; i--) frame_q.push_back(8'(i + 1));
        run_frame("len16_pal", 1'b0, 8, 1'b1, 1'b0, 5'd16);
        frame_q = '{};
        for (int i = 0; i < 17; i++) frame_q.push_back(8'h00);
        run_frame("len17_ovf", 1'b0, 0, 1'b0, 1'b1, 5'd16);
        frame_q = '{};
        for (int i = 0; i < 18; i++) frame_q.push_back(8'h00);
        run_frame("len18_ovf", 1'b0, 0, 1'b0, 1'b1, 5'd16);
        // Sticky overflow must not leak into the next frame.
        frame_q = '{8'h44, 8'h44};
        run_frame("after_ovf", 1'b0, 1, 1'b1, 1'b0, 5'd2);
    endtask

    task automatic test_early_exit();
        int exp_cyc;
`ifdef PALIN_EARLY_EXIT_EN
        exp_cyc = 1;
`else
        exp_cyc = 2;
`endif
        frame_q = '{8'hAA, 8'h00, 8'h00, 8'h55};
        run_frame("early_exit", 1'b0, exp_cyc, 1'b0, 1'b0, 5'd4);
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        bit stable;
        frame_q = '{8'h01, 8'h80};
        send_frame(1'b1, ok);
        wait_result(cyc);
        stable = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || is_palindrome !== 1'b1 ||
                overflow !== 1'b0 || frame_len !== 5'd2) stable = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        total_cnt++;
        if (!stable || cyc != 1)
            $display("FAIL backpressure_hold: stable=%0d cyc=%0d want stable=1 cyc=1", stable, cyc);
        else pass_cnt++;
        release_result();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_check();
        bit ok;
        bit seen;
        frame_q = '{};
        for (int i = 0; i < 16; i++) frame_q.push_back(8'h11);
        send_frame(1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_len !== 5'd0)
            $display("FAIL rst_mid_check_async: ov=%b rdy=%b len=%0d want 0 1 0", out_valid, in_ready, frame_len);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen)
            $display("FAIL rst_mid_check_no_result: out_valid rose want stays 0");
        else pass_cnt++;
        frame_q = '{8'h5A};
        run_frame("after_rst_5A", 1'b1, 1, 1'b1, 1'b0, 5'd1);
    endtask

    initial begin
        test_reset();
        test_sym_mode();
        test_bit_mode();
        test_overflow();
        test_early_exit();
        test_backpressure();
        test_reset_mid_check();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_palin_stream_detector

// File: doc/palin_stream_detector.md
PALIN_STREAM_DETECTOR -- requirements
Module: palin_stream_detector

Interface
REQ-001 SHALL have parameter SYM_W, default 8, symbol width in bits (>=1).
REQ-002 SHALL have parameter MAX_LEN, default 16, frame buffer depth in symbols (>=2, power of two not required).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input symbol valid.
REQ-006 SHALL have port in_ready  output  1  block accepts symbol this cycle.
REQ-007 SHALL have port in_data  input  SYM_W  input symbol.
REQ-008 SHALL have port in_last  input  1  marks final symbol of frame.
REQ-009 SHALL have port mode  input  1  0 = symbol-order palindrome, 1 = full bit-string palindrome; sampled with first symbol of frame.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port is_palindrome  output  1  frame verdict.
REQ-013 SHALL have port overflow  output  1  frame exceeded MAX_LEN.
REQ-014 SHALL have port frame_len  output  $clog2(MAX_LEN+1)  accepted symbol count, saturating at MAX_LEN.

Function
REQ-015 SHALL implement states LOAD, CHECK, RESULT; transfer occurs when valid && ready.
REQ-016 LOAD: in_ready=1; each transfer SHALL write in_data to buf[len] and increment len while len<MAX_LEN.
REQ-017 Transfer with len==MAX_LEN and in_last=0 SHALL discard the symbol and set sticky ovf flag; symbols discarded until in_last.
REQ-018 Transfer with in_last=1 SHALL go to CHECK (or RESULT with is_palindrome=0, overflow=1 if ovf set or last symbol itself overflows).
REQ-019 CHECK: in_ready=0; iteration k (k=0,1,..) SHALL compare buf[k] with buf[len-1-k], one comparison per cycle.
REQ-020 Mode 0 compare: equality; mode 1 compare: buf[k] == bit-reverse(buf[len-1-k]).
REQ-021 Mode 1, odd len: middle symbol (k==len-1-k) SHALL also equal its own bit-reverse; mode 0 middle symbol always matches.
REQ-022 CHECK SHALL end after iteration floor((len-1)/2) (CHECK lasts ceil(len/2) cycles) and go to RESULT; verdict = all compares matched.
REQ-023 Single-symbol frame: mode 0 -> is_palindrome=1; mode 1 -> 1 iff symbol is bit-palindrome.
REQ-024 RESULT: out_valid=1, is_palindrome/overflow/frame_len held stable until out_ready; on handshake SHALL clear len/ovf and return to LOAD next cycle.
REQ-025 out_valid and in_ready SHALL never be 1 together.

Reset
REQ-026 rst SHALL asynchronously force LOAD, len=0, ovf=0, out_valid=0, is_palindrome=0, overflow=0, frame_len=0; buffer contents need not reset.
REQ-027 rst mid-CHECK or mid-RESULT SHALL abandon the frame; no result emitted for it.

Configuration
REQ-028 Macro PALIN_EARLY_EXIT_EN defined: first mismatch in CHECK SHALL go to RESULT next cycle.
REQ-029 Macro undefined: CHECK SHALL always run ceil(len/2) cycles regardless of mismatches (data-independent latency); verdicts identical either way.

Structure
REQ-030 Package palin_pkg SHALL hold state enum (LOAD, CHECK, RESULT) and mode constants MODE_SYM=0, MODE_BIT=1.
REQ-031 Sub-module palin_sym_cmp SHALL be the combinational pair comparator (SYM_W param, mode, bit-reverse).

Verification
REQ-032 SYM_W=8, mode 0, frame 0x12,0x34,0x12 -> after 2 CHECK cycles out_valid=1, is_palindrome=1, frame_len=3.
REQ-033 mode 1, frame 0x01,0x80 -> is_palindrome=1; same frame mode 0 -> 0.
REQ-034 MAX_LEN=16, 18-symbol frame -> overflow=1, is_palindrome=0, frame_len=16, no CHECK cycles.
REQ-035 mode 0, frame 0xAA,0x00,0x00,0x55 with EARLY_EXIT_EN -> RESULT after 1 CHECK cycle, verdict 0; without macro -> after 2 cycles, verdict 0.
REQ-036 Hold out_ready=0 10 cycles -> outputs stable, in_ready=0; rst asserted during CHECK -> out_valid stays 0, next frame 0x5A (mode 1) -> is_palindrome=1.
